// File: rtl/led_blink_sched.sv
// Round-robin owner of the single status LED: each granted requester gets
// its burst of blinks followed by a dark gap, then a one-cycle done pulse.
module led_blink_sched #(
    parameter int N_REQ              = 4,
    parameter int CNT_W              = 4,
    parameter int HALF_PERIOD_CYCLES = 12500000,
    parameter int GAP_HALF_PERIODS   = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [N_REQ-1:0]         req,
    input  logic [N_REQ*CNT_W-1:0]   cnt,
    output logic [N_REQ-1:0]         gnt,
    output logic [N_REQ-1:0]         done,
    output logic                     led,
    output logic                     busy
);

    localparam int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int PW    = (HALF_PERIOD_CYCLES > 1) ? $clog2(HALF_PERIOD_CYCLES) : 1;
    localparam int GW    = (GAP_HALF_PERIODS > 1) ? $clog2(GAP_HALF_PERIODS) : 1;

    localparam logic [PW-1:0]    PRESC_MAX = PW'(HALF_PERIOD_CYCLES - 1);
    localparam logic [GW-1:0]    GAP_LAST  = GW'(GAP_HALF_PERIODS - 1);
    localparam logic [PTR_W-1:0] PTR_LAST  = PTR_W'(N_REQ - 1);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] ON   = 2'd1;
    localparam logic [1:0] OFF  = 2'd2;
    localparam logic [1:0] GAP  = 2'd3;

    logic [1:0]       state;
    logic [PW-1:0]    presc;
    logic [GW-1:0]    gcnt;
    logic [CNT_W-1:0] remaining;
    logic [PTR_W-1:0] rr_ptr;
    logic [PTR_W-1:0] owner;

    logic             tick;
    logic [PTR_W-1:0] win;
    logic [PTR_W:0]   sum;
    logic             found;
    logic [CNT_W-1:0] cnt_sel;

    function automatic logic [N_REQ-1:0] onehot(input logic [PTR_W-1:0] i);
        logic [N_REQ-1:0] v;
        v    = '0;
        v[i] = 1'b1;
        return v;
    endfunction

    assign tick = (presc == PRESC_MAX);

    // First requesting index at or after rr_ptr, wrapping modulo N_REQ.
    always_comb begin
        win   = '0;
        found = 1'b0;
        sum   = '0;
        for (int k = 0; k < N_REQ; k++) begin
            sum = {1'b0, rr_ptr} + (PTR_W+1)'(k);
            if (sum >= (PTR_W+1)'(N_REQ))
                sum = sum - (PTR_W+1)'(N_REQ);
            if (!found && req[sum[PTR_W-1:0]]) begin
                found = 1'b1;
                win   = sum[PTR_W-1:0];
            end
        end
        cnt_sel = cnt[win*CNT_W +: CNT_W];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            presc     <= '0;
            gcnt      <= '0;
            remaining <= '0;
            rr_ptr    <= '0;
            owner     <= '0;
            gnt       <= '0;
            done      <= '0;
            led       <= 1'b0;
            busy      <= 1'b0;
        end else begin
            done <= '0;
            // State changes only happen on tick, where presc wraps to 0 anyway,
            // so every state entry sees a cleared prescaler.
            if (state == IDLE || tick)
                presc <= '0;
            else
                presc <= presc + 1'b1;

            case (state)
                IDLE: begin
                    if (found) begin
                        owner     <= win;
                        gnt       <= onehot(win);
                        busy      <= 1'b1;
                        remaining <= cnt_sel;
                        gcnt      <= '0;
                        if (cnt_sel != '0) begin
                            state <= ON;
                            led   <= 1'b1;
                        end else begin
                            state <= GAP;
                        end
                    end
                end
                ON: begin
                    if (tick) begin
                        state <= OFF;
                        led   <= 1'b0;
                    end
                end
                OFF: begin
                    if (tick) begin
                        remaining <= (remaining != '0) ? remaining - 1'b1 : '0;
                        if (remaining <= CNT_W'(1)) begin
                            state <= GAP;
                            gcnt  <= '0;
                        end else begin
                            state <= ON;
                            led   <= 1'b1;
                        end
                    end
                end
                GAP: begin
                    if (tick) begin
                        if (gcnt == GAP_LAST) begin
                            state  <= IDLE;
                            gnt    <= '0;
                            busy   <= 1'b0;
                            done   <= onehot(owner);
                            rr_ptr <= (owner == PTR_LAST) ? '0 : owner + 1'b1;
                        end else begin
                            gcnt <= gcnt + 1'b1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_led_blink_sched.sv
// Directed bench for led_blink_sched with a 2-cycle half-period and 2-half-period gap.
module tb_led_blink_sched;

    localparam int N_REQ = 4;
    localparam int CNT_W = 4;

    logic                   clk = 1'b0;
    logic                   rst;
    logic [N_REQ-1:0]       req;
    logic [N_REQ*CNT_W-1:0] cnt;
    logic [N_REQ-1:0]       gnt;
    logic [N_REQ-1:0]       done;
    logic                   led;
    logic                   busy;

    int checks = 0;
    int errors = 0;

    led_blink_sched #(
        .N_REQ(N_REQ),
        .CNT_W(CNT_W),
        .HALF_PERIOD_CYCLES(2),
        .GAP_HALF_PERIODS(2)
    ) dut (
        .clk (clk),
        .rst (rst),
        .req (req),
        .cnt (cnt),
        .gnt (gnt),
        .done(done),
        .led (led),
        .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, "_gnt"},  32'(gnt),  32'h0);
        chk({tag, "_done"}, 32'(done), 32'h0);
        chk({tag, "_led"},  32'(led),  32'h0);
        chk({tag, "_busy"}, 32'(busy), 32'h0);
    endtask

    task automatic pulse_reset();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
    endtask

    initial begin
        logic [3:0] eg, ed, own;
        logic       el;
        int s, p;

        rst = 1'b1;
        req = '0;
        cnt = '0;

        // 1: held in reset, then idle with no requests
        step();
        step();
        chk_idle("t1_in_reset");
        rst = 1'b0;
        for (int j = 0; j < 20; j++) begin
            step();
            chk({"t1_gnt"}, 32'(gnt), 32'h0);
            chk({"t1_out"}, 32'({done, led, busy}), 32'h0);
        end

        // 2: single requester, cnt=3
        cnt = 16'h0003;
        req = 4'b0001;
        for (int j = 1; j <= 17; j++) begin
            step();
            eg = (j <= 16) ? 4'b0001 : 4'b0000;
            ed = (j == 17) ? 4'b0001 : 4'b0000;
            el = (j <= 12) && (((j - 1) % 4) < 2);
            chk("t2_gnt",  32'(gnt),  32'(eg));
            chk("t2_done", 32'(done), 32'(ed));
            chk("t2_led",  32'(led),  32'(el));
            chk("t2_busy", 32'(busy), 32'(j <= 16));
            if (j == 17) req = 4'b0000;
        end
        step();
        chk_idle("t2_after");

        // 3: all four requesting, cnt=1 each, served in rotation
        pulse_reset();
        cnt = 16'h1111;
        req = 4'b1111;
        for (int j = 1; j <= 45; j++) begin
            step();
            s   = (j - 1) / 9;
            p   = (j - 1) % 9;
            own = 4'b0001 << (s % 4);
            eg  = (p < 8) ? own : 4'b0000;
            ed  = (p == 8) ? own : 4'b0000;
            el  = (p < 2);
            chk("t3_gnt",  32'(gnt),  32'(eg));
            chk("t3_done", 32'(done), 32'(ed));
            chk("t3_led",  32'(led),  32'(el));
        end

        // 4: requesters 0 and 2 alternate, cnt=2 each
        req = 4'b0000;
        pulse_reset();
        cnt = 16'h0202;
        req = 4'b0101;
        for (int j = 1; j <= 52; j++) begin
            step();
            s   = (j - 1) / 13;
            p   = (j - 1) % 13;
            own = (s % 2 == 0) ? 4'b0001 : 4'b0100;
            eg  = (p < 12) ? own : 4'b0000;
            ed  = (p == 12) ? own : 4'b0000;
            el  = (p < 8) && ((p % 4) < 2);
            chk("t4_gnt",  32'(gnt),  32'(eg));
            chk("t4_done", 32'(done), 32'(ed));
            chk("t4_led",  32'(led),  32'(el));
        end

        // 5: cnt=0 gives a gap-only service
        req = 4'b0000;
        pulse_reset();
        cnt = 16'h0000;
        req = 4'b0010;
        for (int j = 1; j <= 5; j++) begin
            step();
            eg = (j <= 4) ? 4'b0010 : 4'b0000;
            ed = (j == 5) ? 4'b0010 : 4'b0000;
            chk("t5_gnt",  32'(gnt),  32'(eg));
            chk("t5_done", 32'(done), 32'(ed));
            chk("t5_led",  32'(led),  32'h0);
            chk("t5_busy", 32'(busy), 32'(j <= 4));
            if (j == 5) req = 4'b0000;
        end

        // 6: asynchronous reset during ON aborts service without done
        cnt = 16'h0005;
        req = 4'b0001;
        step();
        chk("t6_gnt_on",  32'(gnt),  32'h1);
        chk("t6_led_on",  32'(led),  32'h1);
        chk("t6_busy_on", 32'(busy), 32'h1);
        #2;
        rst = 1'b1;
        #1;
        chk_idle("t6_async");
        req = 4'b0011;
        for (int j = 0; j < 3; j++) begin
            step();
            chk_idle("t6_in_reset");
        end
        rst = 1'b0;
        for (int j = 1; j <= 3; j++) begin
            step();
            chk("t6_regnt", 32'(gnt),  32'h1);
            chk("t6_led",   32'(led),  32'(j <= 2));
            chk("t6_done",  32'(done), 32'h0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
